sdr_memtest: RTL and testbench

SDR_MEMTEST -- requirements
Module: sdr_memtest

---
 rtl/sdr_memtest.sv | 225 ++++++++++++++++++++++
 tb/tb_sdr_memtest.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_memtest.sv
// sdr_memtest: writes an address-derived pattern over a linear word
// range, then reads it back and checks every word.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        launch a test / stop early (level)
//   base_addr, len      first word address, number of words
//   req, we, laddr,     controller request bundle, held until done
//   wrdata
//   done, rddata        controller completion pulse, read data
//   busy, finish        test running / one-cycle end pulse
//   pass, fail          result flags, held until the next start
//   err_cnt             mismatch count, saturating
//   first_err_addr      address of the first mismatching word
module sdr_memtest (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [24:0] base_addr,
  input  logic [24:0] len,
  output logic        req,
  output logic        we,
  output logic [24:0] laddr,
  output logic [63:0] wrdata,
  input  logic        done,
  input  logic [63:0] rddata,
  output logic        busy,
  output logic        finish,
  output logic        pass,
  output logic        fail,
  output logic [15:0] err_cnt,
  output logic [24:0] first_err_addr
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, CHECK, FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [24:0] base_q, base_d;
  logic [24:0] len_q, len_d;
  logic [24:0] idx_q, idx_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [24:0] laddr_q, laddr_d;
  logic [63:0] wrdata_q, wrdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [15:0] err_q, err_d;
  logic [24:0] ferr_q, ferr_d;
  logic        abt_q, abt_d;

  logic [24:0] addr_cur;
  logic [24:0] addr_nxt;
  logic        last;
  logic        stop;

  function automatic logic [63:0] pattern(
    input logic [24:0] a
  );
    return {7'h00, a, 7'h7F, ~a};
  endfunction

  // 25-bit adds wrap the address space naturally
  assign addr_cur = base_q + idx_q;
  assign addr_nxt = addr_cur + 25'd1;
  assign last     = (idx_q == len_q - 25'd1);
  // abort is honoured only between transactions
  assign stop     = abt_q | abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    req_d    = req_q;
    we_d     = we_q;
    laddr_d  = laddr_q;
    wrdata_d = wrdata_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    abt_d    = abt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = len;
          idx_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          abt_d   = 1'b0;
          state_d = (len == '0) ? FINISH : WRITE;
        end
      end
      WRITE: begin
        abt_d = abt_q | abort;
        if (req_q) begin
          if (done) begin
            req_d = 1'b0;
            if (stop) begin
              state_d = FINISH;
            end else if (last) begin
              idx_d   = '0;
              state_d = READ;
            end else begin
              idx_d = idx_q + 25'd1;
            end
          end
        end else if (stop) begin
          state_d = FINISH;
        end else begin
          req_d    = 1'b1;
          we_d     = 1'b1;
          laddr_d  = addr_cur;
          wrdata_d = pattern(addr_cur);
        end
      end
      READ: begin
        abt_d = abt_q | abort;
        if (req_q) begin
          if (done) begin
            req_d   = 1'b0;
            rdata_d = rddata;
            state_d = CHECK;
          end
        end else if (stop) begin
          state_d = FINISH;
        end else begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          laddr_d = addr_cur;
        end
      end
      CHECK: begin
        abt_d = abt_q | abort;
        if (rdata_q != pattern(laddr_q)) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == '0) ferr_d = laddr_q;
        end
        if (last || stop) begin
          state_d = FINISH;
        end else begin
          // issue the next read now so req idles one cycle only
          idx_d   = idx_q + 25'd1;
          req_d   = 1'b1;
          we_d    = 1'b0;
          laddr_d = addr_nxt;
          state_d = READ;
        end
      end
      FINISH: begin
        finish_d = 1'b1;
        pass_d   = (err_q == '0) && !abt_q;
        fail_d   = !((err_q == '0) && !abt_q);
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      laddr_q  <= '0;
      wrdata_q <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= '0;
      ferr_q   <= '0;
      abt_q    <= 1'b0;
    end else begin
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      we_q     <= we_d;
      laddr_q  <= laddr_d;
      wrdata_q <= wrdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      ferr_q   <= ferr_d;
      abt_q    <= abt_d;
    end
  end

  assign req            = req_q;
  assign we             = we_q;
  assign laddr          = laddr_q;
  assign wrdata         = wrdata_q;
  assign busy           = busy_q;
  assign finish         = finish_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sdr_memtest.sv
// tb_sdr_memtest: scoreboarded bench for sdr_memtest with a
// memory responder of programmable latency and read corruption.
module tb_sdr_memtest;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [24:0] base_addr = '0;
  logic [24:0] len = '0;
  logic        req;
  logic        we;
  logic [24:0] laddr;
  logic [63:0] wrdata;
  logic        done = 1'b0;
  logic [63:0] rddata = '0;
  logic        busy;
  logic        finish;
  logic        pass;
  logic        fail;
  logic [15:0] err_cnt;
  logic [24:0] first_err_addr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        w;
    logic [24:0] a;
    logic [63:0] d;
  } txn_t;

  txn_t        sb[$];
  logic [63:0] mem [logic [24:0]];
  int          lat = 3;
  bit          cor_en = 1'b0;
  logic [24:0] cor_a = '0;
  logic [24:0] cor_b = '0;
  int          txn_count = 0;

  sdr_memtest dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .base_addr(base_addr), .len(len),
    .req(req), .we(we), .laddr(laddr),
    .wrdata(wrdata), .done(done),
    .rddata(rddata), .busy(busy),
    .finish(finish), .pass(pass),
    .fail(fail), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(
    input logic [24:0] a
  );
    return {7'h00, a, 7'h7F, ~a};
  endfunction

  task automatic push_txn(input logic w,
                          input logic [24:0] a,
                          input logic [63:0] d);
    txn_t t;
    t.w = w;
    t.a = a;
    t.d = d;
    sb.push_back(t);
  endtask

  task automatic expect_run(input logic [24:0] b,
                            input logic [24:0] n);
    logic [24:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 25'(i);
      push_txn(1'b1, a, pat(a));
    end
    for (int i = 0; i < int'(n); i++) begin
      a = b + 25'(i);
      push_txn(1'b0, a, '0);
    end
  endtask

  // responder + scoreboard consumer, runs on falling edges
  task automatic monitor();
    bit   in_txn = 1'b0;
    bit   done_sent = 1'b0;
    int   cnt = 0;
    int   gap = -1;
    txn_t h;
    txn_t e;
    logic [63:0] rd;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        in_txn = 1'b0;
        done_sent = 1'b0;
        gap = -1;
        done = 1'b0;
        continue;
      end
      done = 1'b0;
      if (done_sent) begin
        checks++;
        if (req !== 1'b0) begin
          errors++;
          $display("FAIL req_drop: req=%b required 0", req);
        end
      end
      done_sent = 1'b0;
      if (busy !== 1'b1) gap = -1;
      if (req === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cnt = 0;
          txn_count++;
          h.w = we;
          h.a = laddr;
          h.d = wrdata;
          if (gap != -1) begin
            checks++;
            if (gap != 1) begin
              errors++;
              $display("FAIL req_gap: idle=%0d required 1", gap);
            end
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: we=%b addr=%h required none",
                     we, laddr);
          end else begin
            e = sb.pop_front();
            if (we !== e.w || laddr !== e.a ||
                (e.w && wrdata !== e.d)) begin
              errors++;
              $display("FAIL txn: we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                       we, laddr, wrdata, e.w, e.a, e.d);
            end
          end
        end else begin
          checks++;
          if (we !== h.w || laddr !== h.a || wrdata !== h.d) begin
            errors++;
            $display("FAIL stable: we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                     we, laddr, wrdata, h.w, h.a, h.d);
          end
        end
        cnt++;
        if (cnt == lat) begin
          done = 1'b1;
          done_sent = 1'b1;
          if (we) begin
            mem[laddr] = wrdata;
          end else begin
            rd = mem.exists(laddr) ? mem[laddr] : '0;
            if (cor_en && (laddr == cor_a || laddr == cor_b))
              rd = rd ^ 64'h1;
            rddata = rd;
          end
        end
      end else begin
        if (in_txn) begin
          in_txn = 1'b0;
          gap = 1;
        end else if (gap >= 0) begin
          gap++;
        end
      end
    end
  endtask

  task automatic do_start(input logic [24:0] b,
                          input logic [24:0] n);
    @(negedge clk);
    base_addr = b;
    len = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int bound,
                             output int cyc,
                             output bit seen);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (finish === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req, we, busy, finish, pass, fail} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: %b required 000000",
               {req, we, busy, finish, pass, fail});
    end
    checks++;
    if (laddr !== '0 || wrdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h required 0",
               laddr, wrdata);
    end
    checks++;
    if (err_cnt !== '0 || first_err_addr !== '0) begin
      errors++;
      $display("FAIL reset_err: cnt=%h addr=%h required 0",
               err_cnt, first_err_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || req !== 1'b0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: busy=%b req=%b finish=%b required 0",
               busy, req, finish);
    end
  endtask

  task automatic test_single();
    int cyc;
    bit seen;
    lat = 3;
    push_txn(1'b1, 25'h0, 64'h00000000_FFFFFFFF);
    push_txn(1'b0, 25'h0, 64'h0);
    do_start(25'h0, 25'd1);
    checks++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_cycle: req=%b busy=%b required 0 1",
               req, busy);
    end
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || we !== 1'b1) begin
      errors++;
      $display("FAIL first_req: req=%b we=%b required 1 1", req, we);
    end
    wait_finish(200, cyc, seen);
    checks++;
    if (!seen || pass !== 1'b1 || fail !== 1'b0 ||
        err_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single: seen=%b pass=%b fail=%b err=%0d busy=%b required 1 1 0 0 0",
               seen, pass, fail, err_cnt, busy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_left: pending=%0d required 0", sb.size());
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL finish_width: finish=%b required 0", finish);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit seen;
    lat = 1;
    expect_run(25'h1FFFFFE, 25'd4);
    do_start(25'h1FFFFFE, 25'd4);
    wait_finish(300, cyc, seen);
    checks++;
    if (!seen || pass !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap: seen=%b pass=%b pending=%0d required 1 1 0",
               seen, pass, sb.size());
    end
  endtask

  task automatic test_corrupt();
    int cyc;
    bit seen;
    lat = 2;
    cor_en = 1'b1;
    cor_a = 25'h12;
    cor_b = 25'h15;
    expect_run(25'h10, 25'd8);
    do_start(25'h10, 25'd8);
    wait_finish(500, cyc, seen);
    checks++;
    if (!seen || err_cnt !== 16'd2 ||
        first_err_addr !== 25'h12) begin
      errors++;
      $display("FAIL corrupt_err: seen=%b err=%0d first=%h required 1 2 12",
               seen, err_cnt, first_err_addr);
    end
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_flags: pass=%b fail=%b required 0 1",
               pass, fail);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt !== 16'd2 || fail !== 1'b1 ||
        first_err_addr !== 25'h12) begin
      errors++;
      $display("FAIL corrupt_hold: err=%0d fail=%b first=%h required 2 1 12",
               err_cnt, fail, first_err_addr);
    end
    cor_en = 1'b0;
  endtask

  task automatic test_len0();
    int cyc;
    bit seen;
    int n0;
    n0 = txn_count;
    do_start(25'h55, 25'd0);
    wait_finish(10, cyc, seen);
    checks++;
    if (!seen || cyc != 1) begin
      errors++;
      $display("FAIL len0_time: seen=%b cycle=%0d required 1 1",
               seen, cyc);
    end
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || txn_count != n0) begin
      errors++;
      $display("FAIL len0: pass=%b fail=%b reqs=%0d required 1 0 0",
               pass, fail, txn_count - n0);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit seen;
    int n0;
    bit hit;
    lat = 3;
    for (int i = 0; i < 3; i++)
      push_txn(1'b1, 25'h80 + 25'(i), pat(25'h80 + 25'(i)));
    n0 = txn_count;
    hit = 1'b0;
    do_start(25'h80, 25'd8);
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (txn_count - n0 >= 3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_wait: reqs=%0d required 3", txn_count - n0);
    end
    abort = 1'b1;
    wait_finish(200, cyc, seen);
    abort = 1'b0;
    checks++;
    if (!seen || fail !== 1'b1 || pass !== 1'b0 ||
        err_cnt !== '0) begin
      errors++;
      $display("FAIL abort: seen=%b fail=%b pass=%b err=%0d required 1 1 0 0",
               seen, fail, pass, err_cnt);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (txn_count - n0 != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_reqs: reqs=%0d pending=%0d required 3 0",
               txn_count - n0, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    bit hit;
    lat = 4;
    hit = 1'b0;
    expect_run(25'h100, 25'd3);
    do_start(25'h100, 25'd3);
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      if (req === 1'b1 && we === 1'b0) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_wait: read req not seen, required one");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: req=%b busy=%b required 0 0",
               req, busy);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume: req=%b busy=%b required 0 0",
               req, busy);
    end
    lat = 2;
    expect_run(25'h100, 25'd3);
    do_start(25'h100, 25'd3);
    wait_finish(300, cyc, seen);
    checks++;
    if (!seen || pass !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_rerun: seen=%b pass=%b pending=%0d required 1 1 0",
               seen, pass, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    lat = 2;
    expect_run(25'h200, 25'd2);
    @(negedge clk);
    base_addr = 25'h200;
    len = 25'd2;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b required 1", busy);
    end
    base_addr = 25'h300;
    len = 25'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(300, cyc, seen);
    checks++;
    if (!seen || pass !== 1'b1 || fail !== 1'b0 ||
        sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_first: seen=%b pass=%b fail=%b pending=%0d required 1 1 0 0",
               seen, pass, fail, sb.size());
    end
    expect_run(25'h300, 25'd2);
    do_start(25'h300, 25'd2);
    wait_finish(300, cyc, seen);
    checks++;
    if (!seen || pass !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_second: seen=%b pass=%b pending=%0d required 1 1 0",
               seen, pass, sb.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_wrap();
    test_corrupt();
    test_len0();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
